// File: rtl/bus_mgr_pkg.sv
// rtl/bus_mgr_pkg.sv - shared types and constants for the bus manager
// Holds the FSM state encoding, the default-width command record and the
// width of the timed-out transaction counter.
package bus_mgr_pkg;

    localparam int TIMEOUT_CNT_W = 8;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

    // Flattened width of a command record for a given address/data width.
    function automatic int cmd_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/bus_mgr_cmd_fifo.sv
// rtl/bus_mgr_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers
// Ports: clk, rst_n (async active-low), push/push_data write side,
// pop read side, full/empty flags, head = entry at the read pointer.
module bus_mgr_cmd_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bus_manager_q.sv
// rtl/bus_manager_q.sv - queued bus manager: command FIFO, slave bus FSM, response register
// Ports: cmd_* valid/ready command input, rsp_* valid/ready response output,
// bus_* simple valid/ready slave bus, busy status, timeout_cnt saturating count.
module bus_manager_q
    import bus_mgr_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_wr,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     bus_valid,
    output logic                     bus_wr_en,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_ready,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic                     busy,
    output logic [TIMEOUT_CNT_W-1:0] timeout_cnt
);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_w_t;

    localparam int CMD_W  = cmd_width(ADDR_W, DATA_W);
    // A zero TIMEOUT would give a zero-width counter; keep one bit then.
    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    state_t            state_d;
    logic [WCNT_W-1:0] wait_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    cmd_w_t            head;
    cmd_w_t            push_cmd;
    logic              push;
    logic              complete;
    logic              timed_out;
    logic              rsp_load;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign push_cmd  = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};

    bus_mgr_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_cmd),
        .pop       (rsp_load),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving IDLE only when the response register is free (or being freed)
    // guarantees a completion never overwrites an unconsumed response.
    // A ready on the final wait cycle beats the timeout.
    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && (!rsp_valid || rsp_ready)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_load = complete || timed_out;

    // Held at zero outside REQ, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_q != REQ) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

    assign bus_valid = (state_q == REQ);
    assign bus_wr_en = bus_valid && head.wr;
    assign bus_addr  = bus_valid ? head.addr : '0;
    assign bus_wdata = (bus_valid && head.wr) ? head.wdata : '0;

    assign busy = !fifo_empty || (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= head.wr;
            rsp_rdata <= (complete && !head.wr) ? bus_rdata : '0;
            rsp_err   <= timed_out;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
        end else if (timed_out && (timeout_cnt != '1)) begin
            timeout_cnt <= timeout_cnt + TIMEOUT_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bus_manager_q.sv
// tb/tb_bus_manager_q.sv - scoreboard bench for bus_manager_q
module tb_bus_manager_q;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_wr;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_valid;
    logic        bus_wr_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        busy;
    logic [7:0]  timeout_cnt;

    bus_manager_q #(
        .ADDR_W(8), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_valid(bus_valid), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          delay;
    } issued_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    issued_t     issued_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] slave_mem [256];
    int          tests = 0;
    int          fails = 0;
    int          exp_tcnt = 0;
    int          rsp_mode = 1;     // 0: hold off, 1: always ready, 2: random
    int          txn_started = 0;
    int          txn_ended = 0;
    int          ended_at_accept = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk(name, {cmd_ready, bus_valid, bus_wr_en, bus_addr, bus_wdata, rsp_valid,
                   rsp_wr, rsp_rdata, rsp_err, busy, timeout_cnt}, {1'b1, 86'd0});
    endtask

    // Offer one command; on acceptance the reference model decides the
    // outcome from the slave delay chosen for it and records the expectation.
    task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input int delay);
        logic rdy;
        bit   done = 0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1;
                ended_at_accept = txn_ended;
                issued_q.push_back('{wr, addr, wdata, delay});
                e.wr  = wr;
                e.err = (delay >= TMO);
                if (wr) begin
                    e.rdata = '0;
                    if (!e.err) model_mem[addr] = wdata;
                end else begin
                    e.rdata = e.err ? 32'd0 : model_mem[addr];
                end
                exp_q.push_back(e);
            end
        end
        #1;
        cmd_valid = 1'b0;
        if (!done) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy || rsp_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 0, 1);
    endtask

    // Response consumer.
    initial forever begin
        @(posedge clk);
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard monitor.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.err && exp_tcnt < 255) exp_tcnt++;
                chk("rsp_fields", {rsp_wr, rsp_err, rsp_rdata}, {e.wr, e.err, e.rdata});
                chk("timeout_cnt", timeout_cnt, exp_tcnt);
            end
        end
    end

    // Slave model: asserts ready on REQ cycle index 'delay' of each transaction.
    initial begin
        issued_t     cur;
        int          cyc = 0;
        bit          in_txn = 0;
        logic [40:0] cap = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_txn    = 0;
                bus_ready = 1'b0;
            end else if (bus_valid) begin
                if (!in_txn) begin
                    in_txn = 1;
                    cyc    = 0;
                    txn_started++;
                    if (issued_q.size() == 0) begin
                        chk("bus_without_cmd", 1, 0);
                        cur = '{1'b0, 8'd0, 32'd0, 0};
                    end else begin
                        cur = issued_q.pop_front();
                    end
                    cap = {bus_wr_en, bus_addr, bus_wdata};
                    chk("bus_head", cap, {cur.wr, cur.addr, cur.wr ? cur.wdata : 32'd0});
                end else begin
                    cyc++;
                    chk("bus_stable", {bus_wr_en, bus_addr, bus_wdata}, cap);
                end
                bus_ready = (cyc == cur.delay);
                if (bus_ready) begin
                    bus_rdata = slave_mem[bus_addr];
                    if (bus_wr_en) slave_mem[bus_addr] = bus_wdata;
                end else begin
                    bus_rdata = $urandom;
                end
            end else begin
                if (in_txn) begin
                    chk("bus_valid_len", cyc + 1, (cur.delay < TMO) ? cur.delay + 1 : TMO);
                    txn_ended++;
                    in_txn = 0;
                end
                bus_ready = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] held;
        int          t0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = $urandom;
            slave_mem[i] = model_mem[i];
        end
        #2;
        check_reset_vals("reset_values");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read with a two-cycle slave wait; also first-command latency.
        send(1'b1, 8'h10, 32'hABCD_1234, 2);
        chk("lat_edge_k", bus_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge_k1", {bus_valid, bus_wr_en, bus_addr, bus_wdata}, {1'b1, 1'b1, 8'h10, 32'hABCD_1234});
        send(1'b0, 8'h10, 32'h5555_5555, 2);
        chk("model_readback", exp_q[exp_q.size()-1].rdata, 32'hABCD_1234);
        drain();

        // FIFO full: four long transactions fill the queue, the fifth stalls.
        for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 32'd0, 255);
        chk("fifo_full_ready", cmd_ready, 0);
        t0 = txn_ended;
        send(1'b1, 8'h20, 32'h1357_9BDF, 0);
        chk("fifo_full_stall", ended_at_accept - t0, 1);
        drain();
        chk("tcnt_after_full", timeout_cnt, 4);

        // Timeout then a following command, then the same-edge race.
        send(1'b0, 8'h30, 32'd0, 255);
        send(1'b0, 8'h10, 32'd0, 1);
        send(1'b0, 8'h20, 32'd0, TMO - 1);
        send(1'b1, 8'h31, 32'hFEED_0001, TMO);
        drain();
        chk("tcnt_after_race", timeout_cnt, 6);

        // Backpressure: one transaction, response held, bus idle.
        rsp_mode = 0;
        @(posedge clk);
        #1;
        t0 = txn_started;
        for (int i = 0; i < 3; i++) send(1'b0, 8'(8 + i), 32'd0, 0);
        repeat (10) @(posedge clk);
        #1;
        held = {rsp_valid, rsp_wr, rsp_err, rsp_rdata};
        repeat (10) @(posedge clk);
        #1;
        chk("bp_txn_count", txn_started - t0, 1);
        chk("bp_bus_idle", bus_valid, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_held", {rsp_valid, rsp_wr, rsp_err, rsp_rdata}, held);
        rsp_mode = 1;
        drain();

        // Randomised traffic.
        rsp_mode = 2;
        for (int i = 0; i < 150; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            if (r <= 5)      d = $urandom_range(0, 3);
            else if (r == 6) d = TMO - 1;
            else if (r == 7) d = TMO;
            else if (r == 8) d = 255;
            else             d = $urandom_range(5, 10);
            send(1'($urandom), 8'($urandom_range(0, 15)), $urandom, d);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rsp_mode = 1;

        // Reset while a transaction is on the bus with two commands queued.
        for (int i = 0; i < 3; i++) send(1'b0, 8'(i), 32'd0, 255);
        chk("rst_pre_busvalid", bus_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid_req");
        issued_q.delete();
        exp_q.delete();
        exp_tcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("rst_after_release", {rsp_valid, bus_valid, busy, cmd_ready}, 4'b0001);

        // Normal operation after the reset.
        send(1'b1, 8'h05, 32'h0BAD_CAFE, 0);
        send(1'b0, 8'h05, 32'd0, 3);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_manager_q.md
Name: bus_manager_q

Overview:
- Synthesisable, parametrised successor to the testbench-style bus manager.
- Accepts read/write commands on a valid/ready command port and buffers them in a CMD_DEPTH FIFO.
- Issues each command in order on the simple valid/ready slave bus (valid, wr_en, addr, wdata / ready, rdata).
- Returns one response per command on a valid/ready response port, with a per-transaction timeout and error flag.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 32, bus data width.
- CMD_DEPTH, 4, command FIFO entries; power of two, >=2.
- TIMEOUT, 16, max cycles in REQ waiting for ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_wr  out  1  type of the completed command.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  transaction timed out.
- bus_valid  out  1  request to slave.
- bus_wr_en  out  1  write enable to slave.
- bus_addr  out  ADDR_W  address to slave.
- bus_wdata  out  DATA_W  write data to slave.
- bus_ready  in  1  slave completion.
- bus_rdata  in  DATA_W  slave read data; valid when bus_ready=1.
- busy  out  1  FIFO non-empty or state != IDLE.
- timeout_cnt  out  8  saturating count of timed-out transactions.

Behaviour:
- Reset (async assert, sync deassert external): FIFO empty, state IDLE.
- Reset values: cmd_ready=1, all bus_* outputs 0, rsp_valid=0, rsp_wr=0, rsp_rdata=0, rsp_err=0, busy=0, timeout_cnt=0.
- FIFO write: push when cmd_valid && cmd_ready.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle (no pass-through).
  - A push into an empty FIFO is visible to the FSM from the next cycle.
- FSM state IDLE:
  - Go to REQ when FIFO non-empty && (!rsp_valid || rsp_ready).
  - This guarantees the single response register never overflows.
- FSM state REQ:
  - bus_valid=1.
  - bus_wr_en, bus_addr and bus_wdata are driven from the FIFO head and held stable.
  - bus_wdata=0 for reads.
  - A wait counter increments each cycle in REQ.
- Completion:
  - Occurs at the posedge where state==REQ && bus_ready.
  - Pop the FIFO and load the response register: rsp_valid=1, rsp_wr=head.wr, rsp_rdata = head.wr ? 0 : bus_rdata, rsp_err=0.
  - Go to IDLE.
- Timeout:
  - Fires when TIMEOUT!=0, the wait counter == TIMEOUT-1, and bus_ready=0.
  - Pop the FIFO, load the response with rsp_err=1, rsp_rdata=0, then go to IDLE.
  - bus_valid drops on the next cycle; timeout_cnt increments, saturating at 255.
  - If bus_ready and timeout land on the same edge, bus_ready wins and the transfer succeeds.
- Outside REQ all bus_* outputs are 0.
- Response register:
  - Clears rsp_valid on rsp_valid && rsp_ready unless reloaded on the same edge; a reload takes priority.
  - Contents are held while rsp_valid && !rsp_ready.
- Latency:
  - Command accepted at edge k → bus_valid high after edge k+1.
  - With ready at edge k+2, rsp_valid is high after edge k+2.
  - Minimum spacing between bus transactions is 2 cycles (one IDLE cycle between them).
- Ordering: strictly in-order, one outstanding bus transaction.
- Reset mid-transaction:
  - Immediately drops bus_valid and discards the FIFO and response.
  - No response is issued for discarded commands.
- Pointers: log2(CMD_DEPTH) bits plus a wrap bit; full/empty come from pointer compare.
- Wait counter: $clog2(TIMEOUT+1) bits; cleared on entry to REQ.

Decomposition:
- Shared package bus_mgr_pkg holds:
  - state enum {IDLE, REQ};
  - parametrised-width cmd struct {wr, addr, wdata} via localparams;
  - TIMEOUT_CNT_W=8.
- One sub-module, bus_mgr_cmd_fifo: synchronous FIFO with push/pop/full/empty/head, async active-low reset.
- FSM, timeout logic and response register live in the top level.

Test Plan:
- Write then read: cmd write 0x10/0xABCD_1234, then read 0x10; slave ready after 2 wait cycles and returns 0xABCD_1234.
  - Expect responses (wr=1, err=0) then (wr=0, rdata=0xABCD_1234, err=0).
  - bus_addr/bus_wdata stable while bus_valid && !bus_ready.
- FIFO full: push 5 commands with bus_ready=0 and TIMEOUT=0.
  - Expect cmd_ready low after 4 accepted; 5th stalls until the first completion.
- Backpressure: rsp_ready=0 with 3 commands queued and ready always 1.
  - Expect exactly one bus transaction, rsp held unchanged, bus_valid=0 until rsp_ready=1.
- Timeout: TIMEOUT=16, slave never ready.
  - Expect bus_valid high exactly 16 cycles, then rsp_err=1, rsp_rdata=0, timeout_cnt=1; the next command proceeds.
- Race: bus_ready asserted on the 16th REQ cycle.
  - Expect success (err=0, rdata captured) and timeout_cnt unchanged.
- Reset mid-REQ: assert rst_n=0 while bus_valid=1 with 2 queued.
  - Expect all outputs at reset values asynchronously, no responses after release, cmd_ready=1.
